// File: rtl/median_share_arb.sv
// Shares one NUM-pixel median engine between two streaming requesters.
// Round-robin grant, full-window buffering, DSI/DSO framing and a WAIT timeout.
module median_share_arb #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM     = 9,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S0_VALID,
  input  logic [WIDTH-1:0] S0_DATA,
  output logic             S0_READY,
  input  logic             S1_VALID,
  input  logic [WIDTH-1:0] S1_DATA,
  output logic             S1_READY,
  output logic             R0_VALID,
  output logic             R1_VALID,
  output logic [WIDTH-1:0] R_DATA,
  output logic [WIDTH-1:0] MED_DI,
  output logic             MED_DSI,
  input  logic [WIDTH-1:0] MED_DO,
  input  logic             MED_DSO,
  output logic [1:0]       GNT,
  output logic             BUSY,
  output logic             TIMEOUT_ERR
);

  localparam int unsigned IdxW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM - 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StStream, StWait} state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [WIDTH-1:0] win_q [NUM];
  logic [WIDTH-1:0] win_d [NUM];
  logic [WIDTH-1:0] med_di_q, med_di_d;
  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic             med_dsi_q, med_dsi_d;
  logic             s0_ready_q, s0_ready_d;
  logic             s1_ready_q, s1_ready_d;
  logic             r0_valid_q, r0_valid_d;
  logic             r1_valid_q, r1_valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic [WIDTH-1:0] in_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      gnt_q      <= 2'b00;
      last_q     <= 1'b0;
      idx_q      <= '0;
      tmr_q      <= '0;
      win_q      <= '{default: '0};
      med_di_q   <= '0;
      r_data_q   <= '0;
      med_dsi_q  <= 1'b1;
      s0_ready_q <= 1'b0;
      s1_ready_q <= 1'b0;
      r0_valid_q <= 1'b0;
      r1_valid_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      win_q      <= win_d;
      med_di_q   <= med_di_d;
      r_data_q   <= r_data_d;
      med_dsi_q  <= med_dsi_d;
      s0_ready_q <= s0_ready_d;
      s1_ready_q <= s1_ready_d;
      r0_valid_q <= r0_valid_d;
      r1_valid_q <= r1_valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Only the granted requester ever sees READY, so the OR is a clean accept.
  assign accept  = (S0_VALID & s0_ready_q) | (S1_VALID & s1_ready_q);
  assign in_data = gnt_q[1] ? S1_DATA : S0_DATA;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    win_d      = win_q;
    med_di_d   = med_di_q;
    r_data_d   = r_data_q;
    r0_valid_d = 1'b0;
    r1_valid_d = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (S0_VALID | S1_VALID) begin
          if (S0_VALID & S1_VALID) gnt_d = last_q ? 2'b01 : 2'b10;
          else                     gnt_d = S1_VALID ? 2'b10 : 2'b01;
          idx_d   = '0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (accept) begin
          win_d[idx_q] = in_data;
          if (idx_q == IdxLast) begin
            // First pixel leaves together with the DSI fall.
            med_di_d = win_d[0];
            idx_d    = IdxW'(1);
            state_d  = StStream;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StStream: begin
        med_di_d = win_q[idx_q];
        if (idx_q == IdxLast) begin
          tmr_d   = '0;
          state_d = StWait;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StWait: begin
        // A result arriving on the last timer cycle still wins over the abort.
        if (MED_DSO) begin
          r_data_d   = MED_DO;
          r0_valid_d = gnt_q[0];
          r1_valid_d = gnt_q[1];
          last_d     = gnt_q[1];
          gnt_d      = 2'b00;
          state_d    = StIdle;
        end else if (tmr_q == TmrLast) begin
          err_d   = 1'b1;
          last_d  = gnt_q[1];
          gnt_d   = 2'b00;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    med_dsi_d  = !((state_d == StStream) || (state_d == StWait));
    busy_d     = (state_d != StIdle);
    s0_ready_d = (state_d == StCollect) && gnt_d[0];
    s1_ready_d = (state_d == StCollect) && gnt_d[1];
  end

  assign S0_READY    = s0_ready_q;
  assign S1_READY    = s1_ready_q;
  assign R0_VALID    = r0_valid_q;
  assign R1_VALID    = r1_valid_q;
  assign R_DATA      = r_data_q;
  assign MED_DI      = med_di_q;
  assign MED_DSI     = med_dsi_q;
  assign GNT         = gnt_q;
  assign BUSY        = busy_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_median_share_arb.sv
// Directed bench for median_share_arb with a behavioural median engine.
// Inputs change at negedge+1; the monitor and engine run on the negedge.
module tb_median_share_arb;

  localparam int W  = 8;
  localparam int N  = 9;
  localparam int TO = 64;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         S0_VALID = 1'b0, S1_VALID = 1'b0;
  logic [W-1:0] S0_DATA = '0, S1_DATA = '0;
  logic         S0_READY, S1_READY, R0_VALID, R1_VALID, MED_DSI, BUSY, TIMEOUT_ERR;
  logic [W-1:0] R_DATA, MED_DI;
  logic [W-1:0] MED_DO = '0;
  logic         MED_DSO = 1'b0;
  logic [1:0]   GNT;

  median_share_arb #(.WIDTH(W), .NUM(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .S0_VALID(S0_VALID), .S0_DATA(S0_DATA), .S0_READY(S0_READY),
    .S1_VALID(S1_VALID), .S1_DATA(S1_DATA), .S1_READY(S1_READY),
    .R0_VALID(R0_VALID), .R1_VALID(R1_VALID), .R_DATA(R_DATA),
    .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_DO(MED_DO), .MED_DSO(MED_DSO),
    .GNT(GNT), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial forever #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int           cyc = 0, fall_cyc = 0, rv_cyc = 0, err_cyc = 0;
  int           di_n = 0, rv0_cnt = 0, rv1_cnt = 0, err_cnt = 0;
  int           acc0 = 0, acc1 = 0, bad_ready = 0;
  logic [71:0]  di_pk = '0;
  logic         prev_dsi = 1'b1, err_prev = 1'b0;
  logic [1:0]   prev_gnt = 2'b00, gnt_at_rv = 2'b11;
  logic [W-1:0] last_rdata = '0;
  logic         busy_at_err = 1'b1, busy_after_err = 1'b1;
  logic [1:0]   gnt_log [$];
  logic [8:0]   rv_log [$];

  // Engine model state
  logic         eng_en = 1'b1, eng_pend = 1'b0, kick = 1'b0;
  int           eng_lat = 5, eng_cd = 0, eng_cnt = 0;
  logic [W-1:0] eng_win [N];
  logic [W-1:0] eng_res = '0, kick_data = '0;

  function automatic logic [W-1:0] med9();
    logic [W-1:0] s [N];
    logic [W-1:0] t;
    for (int i = 0; i < N; i++) s[i] = eng_win[i];
    for (int i = 0; i < N - 1; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[N/2];
  endfunction

  function automatic logic [71:0] seq(input int base);
    logic [71:0] r;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = 8'(base + i);
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (prev_dsi && !MED_DSI) begin fall_cyc = cyc; di_n = 0; di_pk = '0; end
      if (!MED_DSI && di_n < N) begin di_pk[di_n*8 +: 8] = MED_DI; di_n++; end
      prev_dsi = MED_DSI;
      if (GNT != 2'b00 && prev_gnt == 2'b00) gnt_log.push_back(GNT);
      prev_gnt = GNT;
      if (R0_VALID) begin
        rv0_cnt++; rv_cyc = cyc; last_rdata = R_DATA; gnt_at_rv = GNT;
        rv_log.push_back({1'b0, R_DATA});
      end
      if (R1_VALID) begin
        rv1_cnt++; rv_cyc = cyc; last_rdata = R_DATA; gnt_at_rv = GNT;
        rv_log.push_back({1'b1, R_DATA});
      end
      if (err_prev) busy_after_err = BUSY;
      err_prev = TIMEOUT_ERR;
      if (TIMEOUT_ERR) begin err_cnt++; err_cyc = cyc; busy_at_err = BUSY; end
      if (S0_VALID && S0_READY) acc0++;
      if (S1_VALID && S1_READY) acc1++;
      if ((S0_READY && GNT != 2'b01) || (S1_READY && GNT != 2'b10)) bad_ready++;

      // Engine: collect N pixels after the DSI fall, answer eng_lat cycles later.
      MED_DSO = 1'b0;
      if (kick) begin
        MED_DSO = 1'b1; MED_DO = kick_data; kick = 1'b0;
      end else if (eng_pend) begin
        if (eng_cd == 0) begin MED_DSO = 1'b1; MED_DO = eng_res; eng_pend = 1'b0; end
        else eng_cd--;
      end
      if (MED_DSI) eng_cnt = 0;
      else if (eng_cnt < N) begin
        eng_win[eng_cnt] = MED_DI;
        eng_cnt++;
        if (eng_cnt == N && eng_en) begin eng_pend = 1'b1; eng_cd = eng_lat; eng_res = med9(); end
      end
    end
  end

  task automatic clear_logs();
    di_n = 0; di_pk = '0; rv0_cnt = 0; rv1_cnt = 0; err_cnt = 0;
    acc0 = 0; acc1 = 0; bad_ready = 0; gnt_at_rv = 2'b11;
    busy_at_err = 1'b1; busy_after_err = 1'b1; last_rdata = '0;
    gnt_log.delete(); rv_log.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1; S0_VALID = 1'b0; S1_VALID = 1'b0; eng_pend = 1'b0; kick = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;
    clear_logs();
  endtask

  task automatic drive(input int ch, input logic v, input logic [W-1:0] d);
    if (ch == 0) begin S0_VALID = v; S0_DATA = d; end
    else         begin S1_VALID = v; S1_DATA = d; end
  endtask

  task automatic send(input int ch, input logic [71:0] pix, input int gap_at, input int gap_len);
    int   i = 0;
    int   g = 0;
    int   guard = 0;
    logic rdy;
    while (i < N && guard < 3000) begin
      @(negedge CLK);
      #1;
      guard++;
      if (i == gap_at && g < gap_len) begin
        g++;
        drive(ch, 1'b0, '0);
      end else begin
        drive(ch, 1'b1, pix[i*8 +: 8]);
        rdy = (ch == 0) ? S0_READY : S1_READY;
        if (rdy) i++;
      end
    end
    if (i < N) check("send_budget", 128'(i), 128'(N));
    @(negedge CLK);
    #1 drive(ch, 1'b0, '0);
  endtask

  task automatic wait_rv(input int n, input int limit);
    int k = 0;
    while ((rv0_cnt + rv1_cnt) < n && k < limit) begin @(negedge CLK); k++; end
    check("rv_arrived", 128'((rv0_cnt + rv1_cnt) >= n), 128'(1));
  endtask

  logic [71:0] pix3;
  logic [7:0]  gpk;
  logic [35:0] rpk;

  initial begin
    // Reset state
    do_reset();
    @(negedge CLK);
    check("rst_dsi", 128'(MED_DSI), 128'(1));
    check("rst_gnt", 128'(GNT), 128'(0));
    check("rst_flags", 128'({S0_READY, S1_READY, R0_VALID, R1_VALID, BUSY, TIMEOUT_ERR}), 128'(0));
    check("rst_data", 128'({R_DATA, MED_DI}), 128'(0));

    // 1: single window 1..9 from S0, latency 5
    eng_en = 1'b1; eng_lat = 5;
    send(0, seq(1), -1, 0);
    wait_rv(1, 100);
    repeat (2) @(negedge CLK);
    check("t1_di_count", 128'(di_n), 128'(N));
    check("t1_di_order", di_pk, seq(1));
    check("t1_r0_count", 128'(rv0_cnt), 128'(1));
    check("t1_r1_count", 128'(rv1_cnt), 128'(0));
    check("t1_rdata", 128'(last_rdata), 128'(5));
    check("t1_rdata_hold", 128'(R_DATA), 128'(5));
    check("t1_latency", 128'(rv_cyc - fall_cyc), 128'(15));
    check("t1_gnt_first", 128'((gnt_log.size() > 0) ? gnt_log[0] : 2'bxx), 128'(2'b01));
    check("t1_gnt_at_rv", 128'(gnt_at_rv), 128'(2'b00));
    check("t1_beats", 128'(acc0), 128'(N));
    check("t1_ready_excl", 128'(bad_ready), 128'(0));
    check("t1_no_err", 128'(err_cnt), 128'(0));

    // 2: both valid from reset, strict alternation S1,S0,S1,S0
    do_reset();
    fork
      begin send(1, seq(10), -1, 0); send(1, seq(30), -1, 0); end
      begin send(0, seq(20), -1, 0); send(0, seq(40), -1, 0); end
    join
    wait_rv(4, 600);
    repeat (2) @(negedge CLK);
    check("t2_gnt_n", 128'(gnt_log.size()), 128'(4));
    gpk = (gnt_log.size() == 4) ? {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]} : 8'hxx;
    check("t2_gnt_order", 128'(gpk), 128'(8'b10_01_10_01));
    rpk = (rv_log.size() == 4) ? {rv_log[0], rv_log[1], rv_log[2], rv_log[3]} : 36'hx;
    check("t2_results", 128'(rpk), 128'({1'b1, 8'd14, 1'b0, 8'd24, 1'b1, 8'd34, 1'b0, 8'd44}));
    check("t2_ready_excl", 128'(bad_ready), 128'(0));

    // 3: S1 stalls for 10 cycles mid-window
    do_reset();
    pix3 = {8'd5, 8'd4, 8'd6, 8'd2, 8'd8, 8'd1, 8'd7, 8'd3, 8'd9};
    send(1, pix3, 4, 10);
    wait_rv(1, 200);
    repeat (2) @(negedge CLK);
    check("t3_no_err", 128'(err_cnt), 128'(0));
    check("t3_di_count", 128'(di_n), 128'(N));
    check("t3_di_order", di_pk, pix3);
    check("t3_r1", 128'({rv1_cnt[7:0], last_rdata}), 128'({8'd1, 8'd5}));
    check("t3_beats", 128'(acc1), 128'(N));

    // 4: engine silent -> timeout
    do_reset();
    eng_en = 1'b0;
    send(0, seq(40), -1, 0);
    for (int k = 0; k < 200 && err_cnt == 0; k++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    check("t4_err_count", 128'(err_cnt), 128'(1));
    check("t4_err_time", 128'(err_cyc - fall_cyc), 128'(N - 1 + TO));
    check("t4_no_rv", 128'(rv0_cnt + rv1_cnt), 128'(0));
    check("t4_busy_at_err", 128'(busy_at_err), 128'(0));
    check("t4_busy_after", 128'(busy_after_err), 128'(0));

    // 5: DSO on the last timer cycle wins
    do_reset();
    eng_en = 1'b1; eng_lat = TO - 2;
    send(0, seq(50), -1, 0);
    wait_rv(1, 200);
    repeat (3) @(negedge CLK);
    check("t5_r0", 128'({rv0_cnt[7:0], last_rdata}), 128'({8'd1, 8'd54}));
    check("t5_no_err", 128'(err_cnt), 128'(0));
    check("t5_rv_time", 128'(rv_cyc - fall_cyc), 128'(N + TO - 1));

    // 6: reset mid-STREAM, then a stray DSO
    do_reset();
    eng_lat = 5;
    send(0, seq(60), -1, 0);
    repeat (3) @(negedge CLK);
    check("t6_in_stream", 128'(MED_DSI), 128'(0));
    #2 RST = 1'b1;
    #1;
    check("t6_rst_dsi", 128'(MED_DSI), 128'(1));
    check("t6_rst_gnt", 128'(GNT), 128'(0));
    check("t6_rst_flags", 128'({S0_READY, S1_READY, R0_VALID, R1_VALID, BUSY}), 128'(0));
    @(negedge CLK);
    #1 RST = 1'b0;
    clear_logs();
    kick_data = 8'hAB; kick = 1'b1;
    repeat (6) @(negedge CLK);
    check("t6_dso_ignored", 128'(rv0_cnt + rv1_cnt), 128'(0));
    check("t6_rdata", 128'(R_DATA), 128'(0));
    check("t6_idle", 128'({BUSY, GNT, TIMEOUT_ERR}), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
